// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back register file slice.
package wb_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;
  localparam int REG_ZERO   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_regfile_if.sv
// WB-stage write bus, ID read ports and retirement trace grouped as one bundle.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) ();

  logic              running;
  logic              RFWr;
  logic [31:0]       pc;
  logic [DATA_W-1:0] wD;
  logic [31:0]       wR;
  logic [ADDR_W-1:0] rR1;
  logic [ADDR_W-1:0] rR2;
  logic [DATA_W-1:0] rD1;
  logic [DATA_W-1:0] rD2;
  logic              retire_valid;
  logic [31:0]       retire_pc;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output running, RFWr, pc, wD, wR, rR1, rR2,
    input  rD1, rD2, retire_valid, retire_pc, retire_count
  );

  modport slave (
    input  running, RFWr, pc, wD, wR, rR1, rR2,
    output rD1, rD2, retire_valid, retire_pc, retire_count
  );

endinterface

// File: rtl/wb_regfile_retire_tracker.sv
// Retirement trace: one-cycle-late valid pulse, last retired PC and a wrapping count.
module wb_regfile_retire_tracker #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             running,
  input  logic [31:0]      pc,
  output logic             retire_valid,
  output logic [31:0]      retire_pc,
  output logic [CNT_W-1:0] retire_count
);

  logic             r_valid;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_count;

  // Every valid WB instruction retires, whether or not it writes a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0000_0000;
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_valid <= running;
      if (running) begin
        r_pc    <= pc;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign retire_valid = r_valid;
  assign retire_pc    = r_pc;
  assign retire_count = r_count;

endmodule

// File: rtl/wb_regfile.sv
// 2**ADDR_W-entry GPR file written from WB, read combinationally by ID,
// with optional same-cycle WB->ID bypass and x0 tied to zero.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [ADDR_W-1:0] w_widx;
  logic              w_we;
  logic              w_unused_wr_hi;
  logic [DATA_W-1:0] r_regs [NREGS];

  assign w_widx         = bus.wR[ADDR_W-1:0];
  assign w_unused_wr_hi = ^bus.wR[31:ADDR_W];
  // running gates everything, so RFWr/wR/wD are don't-care on bubbles
  assign w_we = bus.running & bus.RFWr & (w_widx != ADDR_W'(REG_ZERO));

  // Register array as plain flops so reset clears it; entry 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_we) begin
      r_regs[w_widx] <= bus.wD;
    end
  end

  // Read port 1: zero register, then bypass, then array.
  always_comb begin
    bus.rD1 = {DATA_W{1'b0}};
    if (bus.rR1 == ADDR_W'(REG_ZERO)) begin
      bus.rD1 = {DATA_W{1'b0}};
    end else if (BYPASS && w_we && (bus.rR1 == w_widx)) begin
      bus.rD1 = bus.wD;
    end else begin
      bus.rD1 = r_regs[bus.rR1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    bus.rD2 = {DATA_W{1'b0}};
    if (bus.rR2 == ADDR_W'(REG_ZERO)) begin
      bus.rD2 = {DATA_W{1'b0}};
    end else if (BYPASS && w_we && (bus.rR2 == w_widx)) begin
      bus.rD2 = bus.wD;
    end else begin
      bus.rD2 = r_regs[bus.rR2];
    end
  end

  wb_regfile_retire_tracker #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk          (clk),
    .rst          (rst),
    .running      (bus.running),
    .pc           (bus.pc),
    .retire_valid (bus.retire_valid),
    .retire_pc    (bus.retire_pc),
    .retire_count (bus.retire_count)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench: a bypassing 32-bit-counter instance and a non-bypassing
// 4-bit-counter instance share stimulus; retirement is scoreboarded per cycle.
module tb_wb_regfile;

  logic clk;
  logic rst;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) ia ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  ib ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32), .BYPASS(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4), .BYPASS(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  typedef struct {
    logic        run;
    logic [31:0] pc;
  } ret_t;

  ret_t        q[$];
  int          checks;
  int          errors;
  logic        cur_run;
  logic [31:0] cur_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_pc;
  logic [31:0] base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic run, input logic rfwr, input logic [31:0] pc,
                     input logic [31:0] wd, input logic [31:0] wr,
                     input logic [4:0] r1, input logic [4:0] r2);
    ia.running = run;  ib.running = run;
    ia.RFWr    = rfwr; ib.RFWr    = rfwr;
    ia.pc      = pc;   ib.pc      = pc;
    ia.wD      = wd;   ib.wD      = wd;
    ia.wR      = wr;   ib.wR      = wr;
    ia.rR1     = r1;   ib.rR1     = r1;
    ia.rR2     = r2;   ib.rR2     = r2;
    cur_run    = run;
    cur_pc     = pc;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drv(1'b0, 1'($urandom), $urandom, $urandom, $urandom, r1, r2);
  endtask

  // Push this cycle's WB instruction, clock it, then check what retired.
  task automatic step();
    ret_t e;
    q.push_back('{run: cur_run, pc: cur_pc});
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (e.run) begin
      m_cnt = m_cnt + 32'd1;
      m_pc  = e.pc;
    end
    chk("ret_valid_a", 64'(ia.retire_valid), 64'(e.run));
    chk("ret_valid_b", 64'(ib.retire_valid), 64'(e.run));
    chk("ret_pc_a",    64'(ia.retire_pc),    64'(m_pc));
    chk("ret_pc_b",    64'(ib.retire_pc),    64'(m_pc));
    chk("ret_cnt_a",   64'(ia.retire_count), 64'(m_cnt));
    chk("ret_cnt_b",   64'(ib.retire_count), 64'(m_cnt[3:0]));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_cnt  = 32'd0;
    m_pc   = 32'd0;
    rst    = 1'b1;
    idle(5'd5, 5'd31);
    #22;
    rst = 1'b0;
    #1;
    chk("rst_rd1_a",   64'(ia.rD1), 64'h0);
    chk("rst_rd2_a",   64'(ia.rD2), 64'h0);
    chk("rst_valid_a", 64'(ia.retire_valid), 64'h0);
    chk("rst_pc_a",    64'(ia.retire_pc), 64'h0);
    chk("rst_cnt_a",   64'(ia.retire_count), 64'h0);
    chk("rst_cnt_b",   64'(ib.retire_count), 64'h0);

    // write reg5, read it back next cycle
    drv(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'd5, 5'd9, 5'd5);
    #1;
    chk("wr_empty_a",  64'(ia.rD1), 64'h0);
    chk("wr_byp_a",    64'(ia.rD2), 64'hDEAD_BEEF);
    chk("wr_nobyp_b",  64'(ib.rD2), 64'h0);
    step();
    idle(5'd5, 5'd0);
    #1;
    chk("rd5_a",  64'(ia.rD1), 64'hDEAD_BEEF);
    chk("rd5_b",  64'(ib.rD1), 64'hDEAD_BEEF);
    chk("rd0_a",  64'(ia.rD2), 64'h0);
    step();

    // same-cycle bypass on both ports
    drv(1'b1, 1'b1, 32'h204, 32'h1234, 32'd7, 5'd7, 5'd7);
    #1;
    chk("byp1_a", 64'(ia.rD1), 64'h1234);
    chk("byp2_a", 64'(ia.rD2), 64'h1234);
    chk("old1_b", 64'(ib.rD1), 64'h0);
    chk("old2_b", 64'(ib.rD2), 64'h0);
    step();
    idle(5'd7, 5'd7);
    #1;
    chk("new1_b", 64'(ib.rD1), 64'h1234);
    chk("new2_b", 64'(ib.rD2), 64'h1234);
    step();

    // x0 write ignored; running=0 gates RFWr; upper wR bits ignored
    drv(1'b1, 1'b1, 32'h208, 32'hFFFF, 32'd0, 5'd0, 5'd0);
    #1;
    chk("x0_byp_a", 64'(ia.rD1), 64'h0);
    step();
    drv(1'b0, 1'b1, 32'h20C, 32'hAAAA, 32'd3, 5'd3, 5'd0);
    #1;
    chk("gate_byp_a", 64'(ia.rD1), 64'h0);
    step();
    idle(5'd3, 5'd0);
    #1;
    chk("gate_a", 64'(ia.rD1), 64'h0);
    chk("gate_b", 64'(ib.rD1), 64'h0);
    drv(1'b1, 1'b1, 32'h210, 32'h5555, 32'h23, 5'd3, 5'd3);
    #1;
    chk("hi_byp_a", 64'(ia.rD1), 64'h5555);
    chk("hi_old_b", 64'(ib.rD1), 64'h0);
    step();
    idle(5'd3, 5'd3);
    #1;
    chk("hi_a", 64'(ia.rD2), 64'h5555);
    chk("hi_b", 64'(ib.rD2), 64'h5555);
    step();

    // four back-to-back retirements, the third without a register write
    base = m_cnt;
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, (k != 2), 32'h100 + 32'(4 * k), 32'hC0DE_0000 + 32'(k),
          32'd10 + 32'(k), 5'd0, 5'd0);
      step();
    end
    idle(5'd12, 5'd13);
    #1;
    chk("ret4_cnt_a", 64'(ia.retire_count), 64'(base + 32'd4));
    chk("ret4_pc_a",  64'(ia.retire_pc), 64'h10C);
    chk("nowr_a",     64'(ia.rD1), 64'h0);
    chk("wr13_a",     64'(ia.rD2), 64'hC0DE_0003);
    step();

    // reset mid-cycle clears immediately; coincident write dropped
    drv(1'b1, 1'b1, 32'h300, 32'h77, 32'd9, 5'd5, 5'd9);
    rst = 1'b1;
    #1;
    chk("mrst_rd5_a", 64'(ia.rD1), 64'h0);
    chk("mrst_byp_a", 64'(ia.rD2), 64'h77);
    chk("mrst_byp_b", 64'(ib.rD2), 64'h0);
    chk("mrst_cnt_a", 64'(ia.retire_count), 64'h0);
    chk("mrst_pc_a",  64'(ia.retire_pc), 64'h0);
    chk("mrst_cnt_b", 64'(ib.retire_count), 64'h0);
    @(posedge clk);
    #1;
    chk("mrst_hold_valid_a", 64'(ia.retire_valid), 64'h0);
    chk("mrst_hold_cnt_a",   64'(ia.retire_count), 64'h0);
    #3;
    rst = 1'b0;
    q.delete();
    m_cnt = 32'd0;
    m_pc  = 32'd0;
    idle(5'd9, 5'd7);
    #1;
    chk("mrst_drop_a", 64'(ia.rD1), 64'h0);
    chk("mrst_clr7_a", 64'(ia.rD2), 64'h0);
    chk("mrst_drop_b", 64'(ib.rD1), 64'h0);

    // 17 retirements wrap the 4-bit counter to 1
    for (int k = 0; k < 17; k++) begin
      drv(1'b1, 1'b0, 32'h400 + 32'(4 * k), $urandom, $urandom, 5'd0, 5'd0);
      step();
    end
    chk("wrap_b", 64'(ib.retire_count), 64'h1);
    chk("wrap_a", 64'(ia.retire_count), 64'd17);
    idle(5'd0, 5'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
